// File: rtl/memory_access_controller_32_pkg.sv
// Shared definitions for the memory access controller: FSM state codes,
// requester grant codes and the transaction-kind helper.
package memory_access_controller_32_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MAR     = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_WR      = 3'd4;
    localparam logic [2:0] ST_ACK     = 3'd5;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    typedef logic [3:0] count_t;

    // Fetches are always reads; the data path reads unless it asks for a store.
    function automatic logic is_read_op(input logic grant, input logic data_we);
        return (grant == GRANT_FETCH) || !data_we;
    endfunction

endpackage

// File: rtl/memory_access_controller_32_rr_arbiter_2.sv
// Two-way round-robin arbiter between instruction fetch and data access.
// Owns the last_grant register that decides ties.
module rr_arbiter_2
    import memory_access_controller_32_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic req_fetch,
    input  logic req_data,
    input  logic enable,
    output logic grant,
    output logic grant_valid
);

    logic last_grant_r;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_valid = req_fetch | req_data;
        if (req_fetch && req_data) begin
            grant = ~last_grant_r;
        end else if (req_data) begin
            grant = GRANT_DATA;
        end else begin
            grant = GRANT_FETCH;
        end
    end

    // Remember the winner only when a grant is actually taken.
    always_ff @(posedge clk) begin
        if (clr) begin
            last_grant_r <= GRANT_FETCH;
        end else if (enable && grant_valid) begin
            last_grant_r <= grant;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/memory_access_controller_32.sv
// Sequencer for the shared MAR/MDR/RAM path: arbitrates fetch vs data
// requests and steps each transaction through its memory strobes.
module memory_access_controller_32
    import memory_access_controller_32_pkg::*;
#(
    parameter int ADDR_WIDTH    = 9,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  in_clk,
    input  logic                  in_clr,
    input  logic                  in_fetch_req,
    input  logic [ADDR_WIDTH-1:0] in_fetch_addr,
    output logic                  out_fetch_ack,
    input  logic                  in_data_req,
    input  logic                  in_data_we,
    input  logic [ADDR_WIDTH-1:0] in_data_addr,
    output logic                  out_data_ack,
    output logic [ADDR_WIDTH-1:0] out_mar_addr,
    output logic                  out_mar_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_mdr_read,
    output logic                  out_mdr_write,
    output logic                  out_busy
);

    logic [2:0]            state_r;
    logic [2:0]            next_state_s;
    count_t                cnt_r;
    logic                  grant_r;
    logic                  is_read_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  arb_grant_s;
    logic                  arb_valid_s;
    logic                  mar_write_r, mem_read_r, mem_write_r;
    logic                  mdr_read_r, mdr_write_r, busy_r;
    logic                  fetch_ack_r, data_ack_r;

    rr_arbiter_2 u_arb (
        .clk         (in_clk),
        .clr         (in_clr),
        .req_fetch   (in_fetch_req),
        .req_data    (in_data_req),
        .enable      (state_r == ST_IDLE),
        .grant       (arb_grant_s),
        .grant_valid (arb_valid_s)
    );

    // Transaction sequencing; requests are only looked at in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:    next_state_s = arb_valid_s ? ST_MAR : ST_IDLE;
            ST_MAR:     next_state_s = is_read_r ? ST_RD_WAIT : ST_WR;
            ST_RD_WAIT: next_state_s = (cnt_r == 4'd1) ? ST_CAPTURE : ST_RD_WAIT;
            ST_CAPTURE: next_state_s = ST_ACK;
            ST_WR:      next_state_s = (cnt_r == 4'd1) ? ST_ACK : ST_WR;
            ST_ACK:     next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // State, latency counter and the grant/op/address latches.
    always_ff @(posedge in_clk) begin
        if (in_clr) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            grant_r   <= GRANT_FETCH;
            is_read_r <= 1'b0;
            addr_r    <= '0;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        grant_r   <= arb_grant_s;
                        is_read_r <= is_read_op(arb_grant_s, in_data_we);
                        addr_r    <= (arb_grant_s == GRANT_DATA) ? in_data_addr : in_fetch_addr;
                    end
                end
                ST_MAR:     cnt_r <= is_read_r ? 4'(READ_LATENCY) : 4'(WRITE_LATENCY);
                ST_RD_WAIT: cnt_r <= cnt_r - 4'd1;
                ST_WR:      cnt_r <= cnt_r - 4'd1;
                default:    cnt_r <= cnt_r;
            endcase
        end
    end

    // Strobes are registered from the upcoming state so each lines up with it.
    always_ff @(posedge in_clk) begin
        if (in_clr) begin
            mar_write_r <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            mdr_read_r  <= 1'b0;
            mdr_write_r <= 1'b0;
            busy_r      <= 1'b0;
            fetch_ack_r <= 1'b0;
            data_ack_r  <= 1'b0;
        end else begin
            mar_write_r <= (next_state_s == ST_MAR);
            mem_read_r  <= (next_state_s == ST_RD_WAIT) || (next_state_s == ST_CAPTURE);
            mem_write_r <= (next_state_s == ST_WR);
            mdr_read_r  <= (next_state_s == ST_CAPTURE);
            mdr_write_r <= (next_state_s == ST_CAPTURE);
            busy_r      <= (next_state_s != ST_IDLE);
            fetch_ack_r <= (next_state_s == ST_ACK) && (grant_r == GRANT_FETCH);
            data_ack_r  <= (next_state_s == ST_ACK) && (grant_r == GRANT_DATA);
        end
    end

    assign out_mar_addr  = addr_r;
    assign out_mar_write = mar_write_r;
    assign out_mem_read  = mem_read_r;
    assign out_mem_write = mem_write_r;
    assign out_mdr_read  = mdr_read_r;
    assign out_mdr_write = mdr_write_r;
    assign out_busy      = busy_r;
    assign out_fetch_ack = fetch_ack_r;
    assign out_data_ack  = data_ack_r;

endmodule

// File: tb/tb_memory_access_controller_32.sv
// Randomized bench for memory_access_controller_32: a transaction-level model
// schedules expected strobes and acks; a negedge monitor compares them.
module tb_memory_access_controller_32;

    localparam int AW = 9;
    localparam int RL = 4;
    localparam int WL = 3;
    localparam int RUN_CYCLES = 3000;

    logic          clk = 1'b0;
    logic          in_clr = 1'b1;
    logic          in_fetch_req = 1'b0;
    logic [AW-1:0] in_fetch_addr = '0;
    logic          in_data_req = 1'b0;
    logic          in_data_we = 1'b0;
    logic [AW-1:0] in_data_addr = '0;
    logic          out_fetch_ack, out_data_ack;
    logic [AW-1:0] out_mar_addr;
    logic          out_mar_write, out_mem_read, out_mem_write;
    logic          out_mdr_read, out_mdr_write, out_busy;

    always #5 clk = ~clk;

    memory_access_controller_32 #(
        .ADDR_WIDTH(AW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .in_clk(clk), .in_clr(in_clr),
        .in_fetch_req(in_fetch_req), .in_fetch_addr(in_fetch_addr), .out_fetch_ack(out_fetch_ack),
        .in_data_req(in_data_req), .in_data_we(in_data_we), .in_data_addr(in_data_addr),
        .out_data_ack(out_data_ack), .out_mar_addr(out_mar_addr), .out_mar_write(out_mar_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_mdr_read(out_mdr_read),
        .out_mdr_write(out_mdr_write), .out_busy(out_busy)
    );

    typedef struct {
        bit            who;      // 0 = fetch, 1 = data
        int            ack_cyc;
        logic [AW-1:0] addr;
    } ack_t;

    ack_t          ack_q[$];
    logic [16:0]   exp_map [int];   // {mar_wr,mem_rd,mem_wr,mdr_rd,mdr_wr,busy,f_ack,d_ack,addr}
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] hold_addr = '0;

    // Reference model state (transaction level)
    int            idle_from = 1;
    bit            last_who = 1'b0;
    int            cur_t = -1, cur_ack = -1;
    bit            cur_who = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    int            fst = 0, dst = 0;   // requester: 0 idle, 1 waiting, 2 granted
    int            resets = 0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return 9'h1FF;
            2:       return 9'h010;
            default: return AW'($urandom_range(0, 511));
        endcase
    endfunction

    task automatic model_grant(input int c);
        bit            who;
        bit            rd;
        int            ack;
        logic [AW-1:0] a;
        logic [7:0]    s;
        if (in_fetch_req && in_data_req) who = ~last_who;
        else who = in_data_req;
        last_who = who;
        rd  = (who == 1'b0) || !in_data_we;
        a   = who ? in_data_addr : in_fetch_addr;
        ack = rd ? c + 3 + RL : c + 2 + WL;
        for (int k = 1; k <= ack - c; k++) begin
            s = 8'b0000_0100;
            if (k == 1) s[7] = 1'b1;
            else if (k == ack - c) s[who ? 0 : 1] = 1'b1;
            else if (!rd) s[5] = 1'b1;
            else if (k <= 1 + RL) s[6] = 1'b1;
            else s = 8'b0101_1100;
            exp_map[c + k] = {s, a};
        end
        ack_q.push_back('{who: who, ack_cyc: ack, addr: a});
        cur_t = c; cur_ack = ack; cur_who = who; cur_addr = a;
        idle_from = ack + 1;
        if (who) dst = 2; else fst = 2;
    endtask

    task automatic model_reset(input int c);
        in_clr = 1'b1;
        resets++;
        for (int k = c + 1; k <= cur_ack; k++)
            if (exp_map.exists(k)) exp_map.delete(k);
        if (ack_q.size() > 0 && ack_q[$].ack_cyc > c) void'(ack_q.pop_back());
        if (cur_who) dst = in_data_req ? 1 : 0;
        else fst = in_fetch_req ? 1 : 0;
        cur_ack = -1;
        idle_from = c + 1;
        last_who = 1'b0;
        hold_addr = '0;
    endtask

    task automatic drive_cycle(input int c, input bit allow);
        bit did_reset;
        bit just_f, just_d;
        did_reset = 1'b0; just_f = 1'b0; just_d = 1'b0;
        in_clr = 1'b0;
        if (cur_ack == c) begin
            hold_addr = cur_addr;
            if (cur_who) begin in_data_req = 1'b0; dst = 0; just_d = 1'b1; end
            else begin in_fetch_req = 1'b0; fst = 0; just_f = 1'b1; end
        end else if (cur_ack > c && c > cur_t) begin
            if ($urandom_range(0, 59) == 0) begin
                model_reset(c);
                did_reset = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                if (cur_who) in_data_req = 1'b0; else in_fetch_req = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                if (cur_who) begin in_data_addr = 9'h0AA; in_data_we = ~in_data_we; end
                else in_fetch_addr = 9'h0AA;
            end
        end
        if (c == 1) begin
            in_data_req = 1'b1; in_data_we = 1'b0; in_data_addr = 9'h010; dst = 1;
        end else if (allow) begin
            if (fst == 0 && !just_f && $urandom_range(0, 2) == 0) begin
                in_fetch_req = 1'b1; in_fetch_addr = pick_addr(); fst = 1;
            end
            if (dst == 0 && !just_d && $urandom_range(0, 2) == 0) begin
                in_data_req = 1'b1; in_data_addr = pick_addr();
                in_data_we = ($urandom_range(0, 1) == 1); dst = 1;
            end
        end
        if (!did_reset && c >= idle_from && (in_fetch_req || in_data_req))
            model_grant(c);
    endtask

    // Monitor: compare every cycle's strobes and pop the scoreboard on acks.
    always @(negedge clk) begin : monitor
        logic [16:0] got_v, exp_v;
        logic [1:0]  got_who, exp_who;
        ack_t        e;
        if (cyc >= 1) begin
            got_v = {out_mar_write, out_mem_read, out_mem_write, out_mdr_read, out_mdr_write,
                     out_busy, out_fetch_ack, out_data_ack, out_mar_addr};
            if (exp_map.exists(cyc)) begin
                exp_v = exp_map[cyc];
                exp_map.delete(cyc);
            end else begin
                exp_v = {8'b0, hold_addr};
            end
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL strobes cyc=%0d got=%h expected=%h", cyc, got_v, exp_v);
            end
            if (out_fetch_ack || out_data_ack) begin
                checks++;
                if (ack_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected cyc=%0d got f=%b d=%b expected none",
                             cyc, out_fetch_ack, out_data_ack);
                end else begin
                    e = ack_q.pop_front();
                    got_who = {out_fetch_ack, out_data_ack};
                    exp_who = e.who ? 2'b01 : 2'b10;
                    if (got_who !== exp_who || cyc != e.ack_cyc || out_mar_addr !== e.addr) begin
                        errors++;
                        $display("FAIL ack cyc=%0d got who=%b addr=%h expected who=%b cyc=%0d addr=%h",
                                 cyc, got_who, out_mar_addr, exp_who, e.ack_cyc, e.addr);
                    end
                end
            end else if (ack_q.size() > 0 && ack_q[0].ack_cyc < cyc) begin
                checks++;
                errors++;
                e = ack_q.pop_front();
                $display("FAIL ack_missing cyc=%0d got none expected who=%0d at cyc=%0d",
                         cyc, e.who, e.ack_cyc);
            end
        end
    end

    initial begin
        @(posedge clk);
        #2;
        for (int i = 0; i < RUN_CYCLES; i++) begin
            drive_cycle(cyc, i < RUN_CYCLES - 100);
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        #1;
        checks++;
        if (ack_q.size() != 0 || exp_map.size() != 0) begin
            errors++;
            $display("FAIL drain got pending_acks=%0d pending_cycles=%0d expected 0 and 0",
                     ack_q.size(), exp_map.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
